// File: rtl/vgafb_fmlarb.sv
// Arbiter sharing one FML 4x64 read port between the vgafb pixel feed (m0) and a secondary fetch client (m1).
// Build option: define VGAFB_FMLARB_RR_EN for strict round-robin instead of fixed priority with a starvation limit.
module vgafb_fmlarb #(
    parameter int fml_depth     = 26,
    parameter int fml_latency   = 1,
    parameter int max_m0_bursts = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [fml_depth-1:0] m0_adr,
    input  logic                 m0_stb,
    output logic                 m0_ack,
    output logic                 m0_dvalid,
    input  logic [fml_depth-1:0] m1_adr,
    input  logic                 m1_stb,
    output logic                 m1_ack,
    output logic                 m1_dvalid,
    output logic [63:0]          m_di,
    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    input  logic                 fml_ack,
    input  logic [63:0]          fml_di
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_LAT  = 2'd2,
        S_DATA = 2'd3
    } state_e;

    localparam logic [2:0] LAT_LOAD = 3'(fml_latency - 1);
    localparam bit         LAT_ONE  = (fml_latency == 1);
`ifndef VGAFB_FMLARB_RR_EN
    localparam logic [7:0] MAX_M0   = 8'(max_m0_bursts);
`endif

    state_e               state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 fml_stb_q, fml_stb_d;
    logic [fml_depth-1:0] fml_adr_q, fml_adr_d;
    logic [2:0]           lat_q, lat_d;
    logic [1:0]           beat_q, beat_d;
    logic [7:0]           starve_q, starve_d;
    logic                 any_req_s;
    logic                 pick_m1_s;
`ifdef VGAFB_FMLARB_RR_EN
    logic                 rr_last_q, rr_last_d;
`endif

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration decision, consumed only in IDLE; rr_last_q set means m1 was served last
    always_comb begin
        any_req_s = m0_stb | m1_stb;
`ifdef VGAFB_FMLARB_RR_EN
        pick_m1_s = m1_stb & (~m0_stb | ~rr_last_q);
`else
        pick_m1_s = m1_stb & (~m0_stb | (starve_q == MAX_M0));
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (fml_ack) begin
                    state_d = LAT_ONE ? S_DATA : S_LAT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_LAT: begin
                if (lat_q <= 3'd1) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_LAT;
                end
            end
            S_DATA: begin
                if (beat_q == 2'd3) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: request/address capture, grant, counters
    always_comb begin
        fml_stb_d = fml_stb_q;
        fml_adr_d = fml_adr_q;
        grant_d   = grant_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        starve_d  = starve_q;
`ifdef VGAFB_FMLARB_RR_EN
        rr_last_d = rr_last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    fml_stb_d = 1'b1;
                    fml_adr_d = pick_m1_s ? m1_adr : m0_adr;
                    grant_d   = pick_m1_s;
`ifdef VGAFB_FMLARB_RR_EN
                    rr_last_d = pick_m1_s;
                    starve_d  = 8'd0;
`else
                    // Only m0 wins taken while m1 waits count towards forcing m1
                    if (pick_m1_s || !m1_stb) begin
                        starve_d = 8'd0;
                    end else if (starve_q != 8'hFF) begin
                        starve_d = starve_q + 8'd1;
                    end else begin
                        starve_d = starve_q;
                    end
`endif
                end else begin
                    fml_stb_d = 1'b0;
                end
            end
            S_REQ: begin
                if (fml_ack) begin
                    fml_stb_d = 1'b0;
                    lat_d     = LAT_LOAD;
                end else begin
                    fml_stb_d = 1'b1;
                end
            end
            S_LAT: begin
                if (lat_q != 3'd0) begin
                    lat_d = lat_q - 3'd1;
                end else begin
                    lat_d = 3'd0;
                end
            end
            S_DATA: beat_d = beat_q + 2'd1;
            default: fml_stb_d = 1'b0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fml_stb_q <= 1'b0;
            fml_adr_q <= '0;
            grant_q   <= 1'b0;
            lat_q     <= 3'd0;
            beat_q    <= 2'd0;
            starve_q  <= 8'd0;
`ifdef VGAFB_FMLARB_RR_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            fml_stb_q <= fml_stb_d;
            fml_adr_q <= fml_adr_d;
            grant_q   <= grant_d;
            lat_q     <= lat_d;
            beat_q    <= beat_d;
            starve_q  <= starve_d;
`ifdef VGAFB_FMLARB_RR_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    // Outputs: ack follows fml_ack in REQ, dvalid marks the granted master's beats
    always_comb begin
        m_di    = fml_di;
        fml_stb = fml_stb_q;
        fml_adr = fml_adr_q;
        if (state_q == S_REQ) begin
            m0_ack = fml_ack & ~grant_q;
            m1_ack = fml_ack & grant_q;
        end else begin
            m0_ack = 1'b0;
            m1_ack = 1'b0;
        end
        if (state_q == S_DATA) begin
            m0_dvalid = ~grant_q;
            m1_dvalid = grant_q;
        end else begin
            m0_dvalid = 1'b0;
            m1_dvalid = 1'b0;
        end
    end

endmodule

// File: tb/tb_vgafb_fmlarb.sv
// Bench for vgafb_fmlarb: directed vector tables on two instances (latency 1 and 3) plus a
// randomized run checked against a burst-timeline reference model.
module tb_vgafb_fmlarb;

    localparam int DW = 26;
    localparam int LA = 1;
    localparam int MB = 2;
    localparam int LB = 3;
    localparam int NC = 1600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, a_m0_stb, a_m1_stb, a_fml_ack, a_m0_ack, a_m1_ack, a_m0_dv, a_m1_dv, a_fml_stb;
    logic [DW-1:0] a_m0_adr, a_m1_adr, a_fml_adr;
    logic [63:0] a_fml_di, a_m_di;
    logic b_rst, b_m0_stb, b_m1_stb, b_fml_ack, b_m0_ack, b_m1_ack, b_m0_dv, b_m1_dv, b_fml_stb;
    logic [DW-1:0] b_m0_adr, b_m1_adr, b_fml_adr;
    logic [63:0] b_fml_di, b_m_di;

    vgafb_fmlarb #(.fml_depth(DW), .fml_latency(LA), .max_m0_bursts(MB)) dut_a (
        .sys_clk(clk), .sys_rst(a_rst),
        .m0_adr(a_m0_adr), .m0_stb(a_m0_stb), .m0_ack(a_m0_ack), .m0_dvalid(a_m0_dv),
        .m1_adr(a_m1_adr), .m1_stb(a_m1_stb), .m1_ack(a_m1_ack), .m1_dvalid(a_m1_dv),
        .m_di(a_m_di), .fml_adr(a_fml_adr), .fml_stb(a_fml_stb), .fml_ack(a_fml_ack), .fml_di(a_fml_di)
    );

    vgafb_fmlarb #(.fml_depth(DW), .fml_latency(LB), .max_m0_bursts(8)) dut_b (
        .sys_clk(clk), .sys_rst(b_rst),
        .m0_adr(b_m0_adr), .m0_stb(b_m0_stb), .m0_ack(b_m0_ack), .m0_dvalid(b_m0_dv),
        .m1_adr(b_m1_adr), .m1_stb(b_m1_stb), .m1_ack(b_m1_ack), .m1_dvalid(b_m1_dv),
        .m_di(b_m_di), .fml_adr(b_fml_adr), .fml_stb(b_fml_stb), .fml_ack(b_fml_ack), .fml_di(b_fml_di)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          s0;
        logic [DW-1:0] ad0;
        logic          s1;
        logic [DW-1:0] ad1;
        logic          ack;
        logic          e_stb;
        logic [DW-1:0] e_adr;
        logic          e_a0;
        logic          e_a1;
        logic          e_d0;
        logic          e_d1;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic s0, input logic [DW-1:0] ad0,
                                input logic s1, input logic [DW-1:0] ad1, input logic ack,
                                input logic e_stb, input logic [DW-1:0] e_adr,
                                input logic e_a0, input logic e_a1, input logic e_d0, input logic e_d1);
        vec_t v;
        v.rst = rst; v.s0 = s0; v.ad0 = ad0; v.s1 = s1; v.ad1 = ad1; v.ack = ack;
        v.e_stb = e_stb; v.e_adr = e_adr; v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_d0 = e_d0; v.e_d1 = e_d1;
        return v;
    endfunction

    task automatic apply(input bit sel, input vec_t v, input string nm);
        logic [63:0] di;
        logic o_stb, o_a0, o_a1, o_d0, o_d1;
        logic [DW-1:0] o_adr;
        logic [63:0] o_di;
        di = {$urandom, $urandom};
        if (!sel) begin
            a_rst = v.rst; a_m0_stb = v.s0; a_m0_adr = v.ad0; a_m1_stb = v.s1; a_m1_adr = v.ad1;
            a_fml_ack = v.ack; a_fml_di = di;
        end else begin
            b_rst = v.rst; b_m0_stb = v.s0; b_m0_adr = v.ad0; b_m1_stb = v.s1; b_m1_adr = v.ad1;
            b_fml_ack = v.ack; b_fml_di = di;
        end
        @(negedge clk);
        o_stb = sel ? b_fml_stb : a_fml_stb;
        o_adr = sel ? b_fml_adr : a_fml_adr;
        o_a0  = sel ? b_m0_ack : a_m0_ack;
        o_a1  = sel ? b_m1_ack : a_m1_ack;
        o_d0  = sel ? b_m0_dv : a_m0_dv;
        o_d1  = sel ? b_m1_dv : a_m1_dv;
        o_di  = sel ? b_m_di : a_m_di;
        chk({nm, ".fml_stb"}, 64'(o_stb), 64'(v.e_stb));
        chk({nm, ".fml_adr"}, 64'(o_adr), 64'(v.e_adr));
        chk({nm, ".m0_ack"}, 64'(o_a0), 64'(v.e_a0));
        chk({nm, ".m1_ack"}, 64'(o_a1), 64'(v.e_a1));
        chk({nm, ".m0_dvalid"}, 64'(o_d0), 64'(v.e_d0));
        chk({nm, ".m1_dvalid"}, 64'(o_d1), 64'(v.e_d1));
        chk({nm, ".m_di"}, o_di, di);
        @(posedge clk);
        #1;
    endtask

    // Reference timeline for dut_a: per-cycle expectations filled in when a burst is granted
    bit ex_stb[NC+16];
    bit ex_fack[NC+16];
    bit ex_ack0[NC+16];
    bit ex_ack1[NC+16];
    bit ex_dv0[NC+16];
    bit ex_dv1[NC+16];
    bit gq[$];

    task automatic run_phase(input int ncyc, input bit both, input bit zd, input bit rst_en, input string nm);
        int next_arb, adr_load, starve;
        bit rr_m1, p0, p1;
        logic [DW-1:0] ad0, ad1, exp_adr, adr_next;
        for (int k = 0; k < NC + 16; k++) begin
            ex_stb[k] = 1'b0; ex_fack[k] = 1'b0; ex_ack0[k] = 1'b0;
            ex_ack1[k] = 1'b0; ex_dv0[k] = 1'b0; ex_dv1[k] = 1'b0;
        end
        gq.delete();
        next_arb = 0; adr_load = -1; starve = 0; rr_m1 = 1'b1;
        p0 = 1'b0; p1 = 1'b0; ad0 = '0; ad1 = '0; exp_adr = '0; adr_next = '0;
        a_rst = 1'b1; a_m0_stb = 1'b0; a_m1_stb = 1'b0; a_fml_ack = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < ncyc; c++) begin
            bit rst_now, w1;
            int ak;
            if (c > 0 && ex_ack0[c-1]) p0 = 1'b0;
            if (c > 0 && ex_ack1[c-1]) p1 = 1'b0;
            if (!p0 && (both || $urandom_range(0, 3) == 0)) begin p0 = 1'b1; ad0 = DW'($urandom); end
            if (!p1 && (both || $urandom_range(0, 5) == 0)) begin p1 = 1'b1; ad1 = DW'($urandom); end
            rst_now = rst_en && ($urandom_range(0, 149) == 0);
            a_rst = rst_now; a_m0_stb = p0; a_m0_adr = ad0; a_m1_stb = p1; a_m1_adr = ad1;
            a_fml_ack = ex_fack[c] | (!ex_stb[c] && ($urandom_range(0, 3) == 0));
            a_fml_di = {$urandom, $urandom};
            if (c == adr_load) exp_adr = adr_next;
            if (!rst_now && c >= next_arb && (p0 || p1)) begin
`ifdef VGAFB_FMLARB_RR_EN
                w1 = p1 && (!p0 || !rr_m1);
                rr_m1 = w1;
`else
                w1 = p1 && (!p0 || starve == MB);
                if (w1 || !p1) starve = 0;
                else if (starve < 255) starve++;
`endif
                ak = c + 1 + (zd ? 0 : $urandom_range(0, 2));
                for (int k = c + 1; k <= ak; k++) ex_stb[k] = 1'b1;
                ex_fack[ak] = 1'b1;
                if (w1) ex_ack1[ak] = 1'b1; else ex_ack0[ak] = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (w1) ex_dv1[ak+LA+k] = 1'b1; else ex_dv0[ak+LA+k] = 1'b1;
                end
                next_arb = ak + LA + 4;
                adr_next = w1 ? ad1 : ad0;
                adr_load = c + 1;
            end
            if (rst_now) begin
                for (int k = c + 1; k < NC + 16; k++) begin
                    ex_stb[k] = 1'b0; ex_fack[k] = 1'b0; ex_ack0[k] = 1'b0;
                    ex_ack1[k] = 1'b0; ex_dv0[k] = 1'b0; ex_dv1[k] = 1'b0;
                end
                next_arb = c + 1; adr_load = c + 1; adr_next = '0; starve = 0; rr_m1 = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("%s.c%0d.fml_stb", nm, c), 64'(a_fml_stb), 64'(ex_stb[c]));
            chk($sformatf("%s.c%0d.fml_adr", nm, c), 64'(a_fml_adr), 64'(exp_adr));
            chk($sformatf("%s.c%0d.m0_ack", nm, c), 64'(a_m0_ack), 64'(ex_ack0[c]));
            chk($sformatf("%s.c%0d.m1_ack", nm, c), 64'(a_m1_ack), 64'(ex_ack1[c]));
            chk($sformatf("%s.c%0d.m0_dvalid", nm, c), 64'(a_m0_dv), 64'(ex_dv0[c]));
            chk($sformatf("%s.c%0d.m1_dvalid", nm, c), 64'(a_m1_dv), 64'(ex_dv1[c]));
            chk($sformatf("%s.c%0d.m_di", nm, c), a_m_di, a_fml_di);
            if (a_m0_ack === 1'b1) gq.push_back(1'b0);
            if (a_m1_ack === 1'b1) gq.push_back(1'b1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t tab_a[$];
        vec_t tab_b[$];
        bit exp_seq[6];
        logic [DW-1:0] m0a, x1, y0, x2, y2;
        m0a = 26'h0001000; x1 = 26'h002ABCD; y0 = 26'h0123456; x2 = 26'h3FFFFFF; y2 = 26'h1555555;
`ifdef VGAFB_FMLARB_RR_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
        // latency 1: single m0 burst acked two cycles after fml_stb rises
        tab_a.push_back(mk(1'b0, 1'b1, m0a, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
        tab_a.push_back(mk(1'b0, 1'b1, m0a, 1'b0, '0, 1'b0, 1'b1, m0a, 1'b0, 1'b0, 1'b0, 1'b0));
        tab_a.push_back(mk(1'b0, 1'b1, m0a, 1'b0, '0, 1'b0, 1'b1, m0a, 1'b0, 1'b0, 1'b0, 1'b0));
        tab_a.push_back(mk(1'b0, 1'b1, m0a, 1'b0, '0, 1'b1, 1'b1, m0a, 1'b1, 1'b0, 1'b0, 1'b0));
        tab_a.push_back(mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, m0a, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            tab_a.push_back(mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, m0a, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 2; i++)
            tab_a.push_back(mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, m0a, 1'b0, 1'b0, 1'b0, 1'b0));
        // latency 3: lone m1, m0 waiting through m1's burst, reset on beat 2, recovery
        tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b1, x1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
        tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b1, x1, 1'b1, 1'b1, x1, 1'b0, 1'b1, 1'b0, 1'b0));
        tab_b.push_back(mk(1'b0, 1'b1, y0, 1'b0, '0, 1'b1, 1'b0, x1, 1'b0, 1'b0, 1'b0, 1'b0));
        tab_b.push_back(mk(1'b0, 1'b1, y0, 1'b0, '0, 1'b0, 1'b0, x1, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            tab_b.push_back(mk(1'b0, 1'b1, y0, 1'b0, '0, 1'b0, 1'b0, x1, 1'b0, 1'b0, 1'b0, 1'b1));
        tab_b.push_back(mk(1'b0, 1'b1, y0, 1'b0, '0, 1'b0, 1'b0, x1, 1'b0, 1'b0, 1'b0, 1'b0));
        tab_b.push_back(mk(1'b0, 1'b1, y0, 1'b0, '0, 1'b1, 1'b1, y0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++)
            tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b1, x2, 1'b0, 1'b0, y0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b1, x2, 1'b0, 1'b0, y0, 1'b0, 1'b0, 1'b1, 1'b0));
        tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b1, x2, 1'b0, 1'b0, y0, 1'b0, 1'b0, 1'b0, 1'b0));
        tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b1, x2, 1'b1, 1'b1, x2, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++)
            tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, x2, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++)
            tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, x2, 1'b0, 1'b0, 1'b0, 1'b1));
        tab_b.push_back(mk(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, x2, 1'b0, 1'b0, 1'b0, 1'b1));
        tab_b.push_back(mk(1'b0, 1'b1, y2, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
        tab_b.push_back(mk(1'b0, 1'b1, y2, 1'b0, '0, 1'b0, 1'b1, y2, 1'b0, 1'b0, 1'b0, 1'b0));
        tab_b.push_back(mk(1'b0, 1'b1, y2, 1'b0, '0, 1'b1, 1'b1, y2, 1'b1, 1'b0, 1'b0, 1'b0));
        tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, y2, 1'b0, 1'b0, 1'b0, 1'b0));
        tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, y2, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, y2, 1'b0, 1'b0, 1'b1, 1'b0));
        tab_b.push_back(mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, y2, 1'b0, 1'b0, 1'b0, 1'b0));

        a_rst = 1'b1; a_m0_stb = 1'b0; a_m1_stb = 1'b0; a_m0_adr = '0; a_m1_adr = '0;
        a_fml_ack = 1'b0; a_fml_di = '0;
        b_rst = 1'b1; b_m0_stb = 1'b0; b_m1_stb = 1'b0; b_m0_adr = '0; b_m1_adr = '0;
        b_fml_ack = 1'b0; b_fml_di = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tab_a.size(); i++) apply(1'b0, tab_a[i], $sformatf("lat1.row%0d", i));
        for (int i = 0; i < tab_b.size(); i++) apply(1'b1, tab_b[i], $sformatf("lat3.row%0d", i));

        run_phase(40, 1'b1, 1'b1, 1'b0, "cont");
        chk("cont.grant_count_ok", 64'(gq.size() >= 6), 64'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < gq.size()) chk($sformatf("cont.grant%0d", i), 64'(gq[i]), 64'(exp_seq[i]));
        end

        run_phase(1500, 1'b0, 1'b0, 1'b1, "rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
